reset_sequencer: RTL

Parametrised PLL-lock filter and multi-domain reset release sequencer. Sits between the PLL and the SoC core(s) in a board top level. Debounces pll_locked, then deasserts N active-low reset outputs one at a time, with a fixed gap between releases. Supports software-requested re-sequencing and, optionally, automatic re-sequencing when lock is lost.

---
 rtl/reset_sequencer_if.sv | 29 ++
 rtl/reset_sequencer.sv | 119 +++++++++++
 2 files changed

// File: rtl/reset_sequencer_if.sv
// Bundle of the PLL-lock / reset-release signals between a board-level
// driver and reset_sequencer. The sequencer connects through the slave
// modport. The driver connects through the master modport and supplies the
// raw lock and the soft-reset request.
interface reset_sequencer_if #(
    parameter int STAGES = 3
);
    logic              pll_locked;
    logic              soft_reset;
    logic              pll_stable;
    logic [STAGES-1:0] stage_reset_n;
    logic              seq_done;

    modport master (
        output pll_locked,
        output soft_reset,
        input  pll_stable,
        input  stage_reset_n,
        input  seq_done
    );

    modport slave (
        input  pll_locked,
        input  soft_reset,
        output pll_stable,
        output stage_reset_n,
        output seq_done
    );
endinterface

// File: rtl/reset_sequencer.sv
// PLL-lock filter and ordered multi-domain reset release.
// The block debounces pll_locked over LOCK_FILTER samples. It then releases
// STAGES active-low resets one at a time, STAGE_DELAY+1 cycles apart.
// Optional macro RESET_SEQ_RELOCK_EN: when defined, losing lock while in RUN
// reasserts every stage and re-sequences. When undefined, RUN only leaves on
// soft_reset or reset_n.
module reset_sequencer #(
    parameter int LOCK_FILTER = 4,
    parameter int STAGES      = 3,
    parameter int STAGE_DELAY = 128
) (
    input  logic               clk_core,
    input  logic               reset_n,
    reset_sequencer_if.slave   bus
);
    localparam int CNT_W = $clog2(STAGE_DELAY + 1);
    localparam int IDX_W = $clog2(STAGES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STAGE_DELAY);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(STAGES - 1);

    typedef enum logic [1:0] {
        LOCKWAIT = 2'd0,
        SEQ      = 2'd1,
        RUN      = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [LOCK_FILTER-1:0] window_q, window_d;
    logic                   pll_stable_q, pll_stable_d;
    logic [STAGES-1:0]      stage_rst_n_q, stage_rst_n_d;
    logic                   seq_done_q, seq_done_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [IDX_W-1:0]       index_q, index_d;
    logic                   release_now;
    logic                   relock_trip;

`ifdef RESET_SEQ_RELOCK_EN
    assign relock_trip = ~pll_stable_q;
`else
    assign relock_trip = 1'b0;
`endif

    // A stage releases once the per-stage counter has reached its terminal value.
    assign release_now = (state_q == SEQ) && (count_q == CNT_MAX);

    // Lock window shifts in the raw lock. Stable means the whole window was high on the previous edge.
    always_comb begin
        window_d     = (window_q << 1) | LOCK_FILTER'(bus.pll_locked);
        pll_stable_d = &window_q;
    end

    // State register plus all datapath flops; everything clears asynchronously.
    always_ff @(posedge clk_core or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= LOCKWAIT;
            window_q      <= '0;
            pll_stable_q  <= 1'b0;
            stage_rst_n_q <= '0;
            seq_done_q    <= 1'b0;
            count_q       <= '0;
            index_q       <= '0;
        end else begin
            state_q       <= state_d;
            window_q      <= window_d;
            pll_stable_q  <= pll_stable_d;
            stage_rst_n_q <= stage_rst_n_d;
            seq_done_q    <= seq_done_d;
            count_q       <= count_d;
            index_q       <= index_d;
        end
    end

    // Next-state: soft_reset overrides everything, including a coincident release.
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOCKWAIT: if (pll_stable_q) state_d = SEQ;
            SEQ: begin
                if (!pll_stable_q)
                    state_d = LOCKWAIT;
                else if (release_now && (index_q == LAST_IDX))
                    state_d = RUN;
            end
            RUN:      if (relock_trip) state_d = LOCKWAIT;
            default:  state_d = LOCKWAIT;
        endcase
        if (bus.soft_reset)
            state_d = LOCKWAIT;
    end

    // Outputs and counters: any transition into or stay in LOCKWAIT reasserts every stage on that edge.
    always_comb begin
        stage_rst_n_d = stage_rst_n_q;
        seq_done_d    = seq_done_q;
        count_d       = count_q;
        index_d       = index_q;
        if (state_d == LOCKWAIT) begin
            stage_rst_n_d = '0;
            seq_done_d    = 1'b0;
            count_d       = '0;
            index_d       = '0;
        end else if (state_q == SEQ) begin
            if (release_now) begin
                // OR-ing in the next bit keeps the outputs thermometer-coded from bit 0.
                stage_rst_n_d = stage_rst_n_q | (STAGES'(1) << index_q);
                count_d       = '0;
                index_d       = index_q + 1'b1;
                seq_done_d    = (index_q == LAST_IDX);
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    assign bus.pll_stable    = pll_stable_q;
    assign bus.stage_reset_n = stage_rst_n_q;
    assign bus.seq_done      = seq_done_q;

endmodule
